biquad_scheduler: RTL and testbench

BIQUAD_SCHEDULER -- requirements
Module: biquad_scheduler

---
 rtl/biquad_pkg.sv | 22 ++
 rtl/biquad_scheduler_if.sv | 39 +++
 rtl/biquad_scheduler.sv | 158 +++++++++++++++
 tb/tb_biquad_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad band scheduler.
// Contents:
//   state_e          - scheduler FSM state encoding
//   SAMPLE_W_DEFAULT - default signed sample width
//   band_w()         - band-index width for a given band count (minimum 1 bit)
package biquad_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StOut   = 2'd3
    } state_e;

    localparam int unsigned SAMPLE_W_DEFAULT = 24;

    // A single band still needs one index bit so the ports never collapse to zero width.
    function automatic int unsigned band_w(input int unsigned num_bands);
        return (num_bands > 1) ? $clog2(num_bands) : 1;
    endfunction

endpackage

// File: rtl/biquad_scheduler_if.sv
// Engine and per-band result bus of the biquad scheduler.
// Signals:
//   eng_start_out/eng_band_out/eng_sample_out - scheduler -> engine request
//   eng_done_in/eng_result_in                 - engine -> scheduler completion
//   band_valid_out/band_idx_out/band_data_out - scheduler -> sink result stream
//   band_ready_in                             - sink -> scheduler backpressure
// Modports: master (scheduler side), slave (engine + sink side).
interface biquad_scheduler_if #(
    parameter int unsigned NUM_BANDS = 16,
    parameter int unsigned SAMPLE_W  = biquad_pkg::SAMPLE_W_DEFAULT
);
    localparam int unsigned BandW = biquad_pkg::band_w(NUM_BANDS);

    logic                eng_start_out;
    logic [BandW-1:0]    eng_band_out;
    logic [SAMPLE_W-1:0] eng_sample_out;
    logic                eng_done_in;
    logic [SAMPLE_W-1:0] eng_result_in;

    logic                band_valid_out;
    logic                band_ready_in;
    logic [BandW-1:0]    band_idx_out;
    logic [SAMPLE_W-1:0] band_data_out;

    modport master (
        output eng_start_out, eng_band_out, eng_sample_out,
        input  eng_done_in, eng_result_in,
        output band_valid_out, band_idx_out, band_data_out,
        input  band_ready_in
    );

    modport slave (
        input  eng_start_out, eng_band_out, eng_sample_out,
        output eng_done_in, eng_result_in,
        input  band_valid_out, band_idx_out, band_data_out,
        output band_ready_in
    );

endinterface

// File: rtl/biquad_scheduler.sv
// Sequences one shared biquad engine across NUM_BANDS bands for every input sample and
// streams the per-band results out over a valid/ready channel.
// Ports:
//   clk_in, rst_n_in         - clock, asynchronous active-low reset
//   sample_valid_in/sample_in - input sample strobe and data
//   bus (master)             - engine request/completion and band result stream
//   busy_out                 - high whenever a frame is in progress
//   frame_done_out           - one-cycle pulse after the last band handshake
//   overrun_out              - sticky: a sample arrived while busy and was dropped
//   overrun_clr_in           - clears overrun_out (and timeout_out); a set wins over a clear
//   timeout_out              - sticky engine-timeout flag, present only with
//                              BIQUAD_SCHED_TIMEOUT_EN defined
// Optional feature macro: BIQUAD_SCHED_TIMEOUT_EN (engine response timeout in WAIT).
module biquad_scheduler
    import biquad_pkg::*;
#(
    parameter int unsigned NUM_BANDS   = 16,
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                sample_valid_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    biquad_scheduler_if.master  bus,
    output logic                busy_out,
    output logic                frame_done_out,
    output logic                overrun_out,
`ifdef BIQUAD_SCHED_TIMEOUT_EN
    output logic                timeout_out,
`endif
    input  logic                overrun_clr_in
);

    localparam int unsigned BandW = band_w(NUM_BANDS);
    localparam logic [BandW-1:0] LastBand = BandW'(NUM_BANDS - 1);

    state_e              state_q, state_d;
    logic [BandW-1:0]    band_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic [BandW-1:0]    idx_q;
    logic [SAMPLE_W-1:0] data_q;
    logic                frame_done_q;
    logic                overrun_q;

    logic accept;
    logic drop;
    logic eng_done;
    logic handshake;
    logic last_band;
    logic timeout_hit;

    assign accept    = (state_q == StIdle) && sample_valid_in;
    assign drop      = (state_q != StIdle) && sample_valid_in;
    // Completions outside WAIT are ignored.
    assign eng_done  = (state_q == StWait) && bus.eng_done_in;
    assign handshake = (state_q == StOut) && bus.band_ready_in;
    assign last_band = (band_q == LastBand);

`ifdef BIQUAD_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // Expiry on the TIMEOUT_CYC-th WAIT cycle; a same-cycle completion wins.
    assign timeout_hit = (state_q == StWait) && !bus.eng_done_in &&
                         (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == StWait) ? cnt_q + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end else if (overrun_clr_in) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout_out = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sample_valid_in) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (bus.eng_done_in || timeout_hit) state_d = StOut;
            StOut:   if (bus.band_ready_in) state_d = last_band ? StIdle : StIssue;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: everything is decoded from registers so reset clears it at once.
    always_comb begin
        bus.eng_start_out  = (state_q == StIssue);
        bus.eng_band_out   = band_q;
        bus.eng_sample_out = sample_q;
        bus.band_valid_out = (state_q == StOut);
        bus.band_idx_out   = idx_q;
        bus.band_data_out  = data_q;
        busy_out           = (state_q != StIdle);
        frame_done_out     = frame_done_q;
        overrun_out        = overrun_q;
    end

    // Datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            band_q       <= '0;
            sample_q     <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= handshake && last_band;

            if (accept) begin
                sample_q <= sample_in;
                band_q   <= '0;
            end else if (handshake && !last_band) begin
                band_q <= band_q + 1'b1;
            end

            if (eng_done) begin
                data_q <= bus.eng_result_in;
                idx_q  <= band_q;
            end else if (timeout_hit) begin
                data_q <= '0;
                idx_q  <= band_q;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr_in) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_biquad_scheduler.sv
// Directed bench for biquad_scheduler with NUM_BANDS=4, SAMPLE_W=24, TIMEOUT_CYC=8.
// A small engine model answers each start with band*0x10 three cycles later.
module tb_biquad_scheduler;
    import biquad_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned SW = 24;

    logic          clk;
    logic          rst_n;
    logic          sample_valid;
    logic [SW-1:0] sample;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic          overrun_clr;
`ifdef BIQUAD_SCHED_TIMEOUT_EN
    logic          timeout;
`endif

    biquad_scheduler_if #(.NUM_BANDS(NB), .SAMPLE_W(SW)) bus ();

    biquad_scheduler #(
        .NUM_BANDS  (NB),
        .SAMPLE_W   (SW),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .sample_valid_in(sample_valid),
        .sample_in      (sample),
        .bus            (bus),
        .busy_out       (busy),
        .frame_done_out (frame_done),
        .overrun_out    (overrun),
`ifdef BIQUAD_SCHED_TIMEOUT_EN
        .timeout_out    (timeout),
`endif
        .overrun_clr_in (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Engine model state.
    int       start_cnt = 0;
    int       eng_cnt   = 0;
    bit       drop_band1 = 1'b0;
    logic [1:0] pend_band = '0;

    typedef struct {
        logic [1:0]    idx;
        logic [SW-1:0] data;
    } vec_t;

    vec_t frame_tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within cycle budget", name);
    endtask

    // Engine: sample start at negedge, raise done for one cycle three cycles later.
    initial begin
        bus.eng_done_in   = 1'b0;
        bus.eng_result_in = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eng_cnt         = 0;
                bus.eng_done_in = 1'b0;
            end else begin
                bus.eng_done_in = 1'b0;
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0 && !(drop_band1 && pend_band == 2'd1)) begin
                        bus.eng_done_in   = 1'b1;
                        bus.eng_result_in = SW'(pend_band) << 4;
                    end
                end
                if (bus.eng_start_out) begin
                    eng_cnt   = 3;
                    pend_band = bus.eng_band_out;
                    start_cnt++;
                end
            end
        end
    end

    task automatic start_sample(input logic [SW-1:0] value);
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = value;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.band_valid_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_start(input logic [1:0] band, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.eng_start_out && bus.eng_band_out == band) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_frame_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail(name);
    endtask

    // Full frame with ready high, checked against the table.
    task automatic run_frame(input string tag);
        for (int k = 0; k < 4; k++) begin
            wait_valid({tag, " band_valid"});
            check({tag, " band_idx"}, 64'(bus.band_idx_out), 64'(frame_tbl[k].idx));
            check({tag, " band_data"}, 64'(bus.band_data_out), 64'(frame_tbl[k].data));
            if (k == 3) check({tag, " frame_done early"}, 64'(frame_done), 64'd0);
        end
        @(negedge clk);
        check({tag, " frame_done pulse"}, 64'(frame_done), 64'd1);
        check({tag, " busy after frame"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, " frame_done width"}, 64'(frame_done), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " eng_start"}, 64'(bus.eng_start_out), 64'd0);
        check({tag, " eng_band"}, 64'(bus.eng_band_out), 64'd0);
        check({tag, " eng_sample"}, 64'(bus.eng_sample_out), 64'd0);
        check({tag, " band_valid"}, 64'(bus.band_valid_out), 64'd0);
        check({tag, " band_idx"}, 64'(bus.band_idx_out), 64'd0);
        check({tag, " band_data"}, 64'(bus.band_data_out), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " frame_done"}, 64'(frame_done), 64'd0);
        check({tag, " overrun"}, 64'(overrun), 64'd0);
`ifdef BIQUAD_SCHED_TIMEOUT_EN
        check({tag, " timeout"}, 64'(timeout), 64'd0);
`endif
    endtask

    initial begin
        int s;
        int n;
        bit ok;

        frame_tbl[0] = '{idx: 2'd0, data: 24'h000000};
        frame_tbl[1] = '{idx: 2'd1, data: 24'h000010};
        frame_tbl[2] = '{idx: 2'd2, data: 24'h000020};
        frame_tbl[3] = '{idx: 2'd3, data: 24'h000030};

        rst_n             = 1'b0;
        sample_valid      = 1'b0;
        sample            = '0;
        overrun_clr       = 1'b0;
        bus.band_ready_in = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: start follows the accepted sample by one cycle.
        s = start_cnt;
        start_sample(24'h100000);
        check("first start", 64'(bus.eng_start_out), 64'd1);
        check("first start band", 64'(bus.eng_band_out), 64'd0);
        check("busy in frame", 64'(busy), 64'd1);
        check("latched sample", 64'(bus.eng_sample_out), 64'h100000);
        run_frame("frame1");
        check("frame1 starts", 64'(start_cnt - s), 64'd4);

        // Backpressure on band 1.
        start_sample(24'h100000);
        wait_valid("stall band0 valid");
        check("stall band0 idx", 64'(bus.band_idx_out), 64'd0);
        @(negedge clk);
        bus.band_ready_in = 1'b0;
        wait_valid("stall band1 valid");
        s = start_cnt;
        for (int i = 0; i < 10; i++) begin
            check("stall valid", 64'(bus.band_valid_out), 64'd1);
            check("stall idx", 64'(bus.band_idx_out), 64'd1);
            check("stall data", 64'(bus.band_data_out), 64'h10);
            check("stall no start", 64'(bus.eng_start_out), 64'd0);
            @(negedge clk);
        end
        check("stall start count", 64'(start_cnt - s), 64'd0);
        bus.band_ready_in = 1'b1;
        wait_valid("stall band2 valid");
        check("after stall idx", 64'(bus.band_idx_out), 64'd2);
        check("after stall data", 64'(bus.band_data_out), 64'h20);
        check("after stall starts", 64'(start_cnt - s), 64'd1);
        wait_frame_done("stall frame_done");

        // Overrun during WAIT of band 2.
        start_sample(24'h100000);
        wait_start(2'd2, "overrun band2 start");
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = 24'h200000;
        @(negedge clk);
        sample_valid = 1'b0;
        check("overrun set", 64'(overrun), 64'd1);
        check("overrun sample kept", 64'(bus.eng_sample_out), 64'h100000);
        wait_frame_done("overrun frame_done");
        check("overrun sample at end", 64'(bus.eng_sample_out), 64'h100000);
        check("overrun sticky", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun cleared", 64'(overrun), 64'd0);

        // Set and clear together, then reset in WAIT of band 2.
        start_sample(24'h100000);
        wait_start(2'd1, "reset band1 start");
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = 24'h200000;
        overrun_clr  = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        check("set beats clear", 64'(overrun), 64'd1);
        wait_start(2'd2, "reset band2 start");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midframe reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy || bus.eng_start_out) ok = 1'b0;
        end
        check("no resume after reset", 64'(ok), 64'd1);
        start_sample(24'h300000);
        check("restart start", 64'(bus.eng_start_out), 64'd1);
        check("restart band", 64'(bus.eng_band_out), 64'd0);
        check("restart sample", 64'(bus.eng_sample_out), 64'h300000);
        run_frame("frame_after_reset");

`ifdef BIQUAD_SCHED_TIMEOUT_EN
        // Engine never answers band 1.
        drop_band1 = 1'b1;
        start_sample(24'h100000);
        wait_start(2'd1, "timeout band1 start");
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (bus.band_valid_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("timeout band1 valid");
        check("timeout latency", 64'(n), 64'd9);
        check("timeout idx", 64'(bus.band_idx_out), 64'd1);
        check("timeout data", 64'(bus.band_data_out), 64'd0);
        check("timeout flag", 64'(timeout), 64'd1);
        wait_frame_done("timeout frame_done");
        drop_band1  = 1'b0;
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("timeout cleared", 64'(timeout), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
